// File: rtl/falafel_req_arbiter_if.sv
// Requester-side and falafel-side handshake bundle for falafel_req_arbiter.
// The arbiter takes the slave view; the requesters/falafel environment takes the master view.
interface falafel_req_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 64
);
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [N_REQ-1:0]        req_is_alloc_i;
  logic [N_REQ*DATA_W-1:0] req_size_i;
  logic [N_REQ*DATA_W-1:0] req_addr_i;
  logic [N_REQ-1:0]        rsp_valid_o;
  logic [N_REQ-1:0]        rsp_ready_i;
  logic                    rsp_is_write_o;
  logic [DATA_W-1:0]       rsp_data_o;
  logic                    fal_req_valid_o;
  logic                    fal_req_ready_i;
  logic                    fal_is_alloc_o;
  logic [DATA_W-1:0]       fal_size_o;
  logic [DATA_W-1:0]       fal_addr_o;
  logic                    fal_rsp_valid_i;
  logic                    fal_rsp_ready_o;
  logic                    fal_rsp_is_write_i;
  logic [DATA_W-1:0]       fal_rsp_data_i;

  modport slave (
    input  req_valid_i, req_is_alloc_i, req_size_i, req_addr_i, rsp_ready_i,
           fal_req_ready_i, fal_rsp_valid_i, fal_rsp_is_write_i, fal_rsp_data_i,
    output req_ready_o, rsp_valid_o, rsp_is_write_o, rsp_data_o,
           fal_req_valid_o, fal_is_alloc_o, fal_size_o, fal_addr_o, fal_rsp_ready_o
  );

  modport master (
    output req_valid_i, req_is_alloc_i, req_size_i, req_addr_i, rsp_ready_i,
           fal_req_ready_i, fal_rsp_valid_i, fal_rsp_is_write_i, fal_rsp_data_i,
    input  req_ready_o, rsp_valid_o, rsp_is_write_o, rsp_data_o,
           fal_req_valid_o, fal_is_alloc_o, fal_size_o, fal_addr_o, fal_rsp_ready_o
  );
endinterface

// File: rtl/falafel_req_arbiter.sv
// Round-robin arbiter sharing one falafel allocator between N_REQ requesters;
// one request in flight at a time, result routed back to the granted requester.
module falafel_req_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  falafel_req_arbiter_if.slave     bus,
  output logic                     busy_o,
  output logic [$clog2(N_REQ)-1:0] grant_idx_o
);
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_RETURN
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic              is_alloc_q, is_alloc_d;
  logic [DATA_W-1:0] size_q, size_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              rsp_is_write_q, rsp_is_write_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              found;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  cand;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      grant_q        <= '0;
      is_alloc_q     <= 1'b0;
      size_q         <= '0;
      addr_q         <= '0;
      rsp_is_write_q <= 1'b0;
      rsp_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_q        <= grant_d;
      is_alloc_q     <= is_alloc_d;
      size_q         <= size_d;
      addr_q         <= addr_d;
      rsp_is_write_q <= rsp_is_write_d;
      rsp_data_q     <= rsp_data_d;
    end
  end

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((32'(rr_ptr_q) + i) % 32'(N_REQ));
      if (!found && bus.req_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d             = state_q;
    rr_ptr_d            = rr_ptr_q;
    grant_d             = grant_q;
    is_alloc_d          = is_alloc_q;
    size_d              = size_q;
    addr_d              = addr_q;
    rsp_is_write_d      = rsp_is_write_q;
    rsp_data_d          = rsp_data_q;
    bus.req_ready_o     = '0;
    bus.rsp_valid_o     = '0;
    bus.fal_req_valid_o = 1'b0;
    bus.fal_rsp_ready_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d    = winner;
          is_alloc_d = bus.req_is_alloc_i[winner];
          size_d     = bus.req_size_i[winner*DATA_W +: DATA_W];
          addr_d     = bus.req_addr_i[winner*DATA_W +: DATA_W];
          rr_ptr_d   = IDX_W'((32'(winner) + 32'd1) % 32'(N_REQ));
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        bus.fal_req_valid_o      = 1'b1;
        bus.req_ready_o[grant_q] = bus.fal_req_ready_i;
        if (bus.fal_req_ready_i) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        bus.fal_rsp_ready_o = 1'b1;
        if (bus.fal_rsp_valid_i) begin
          rsp_is_write_d = bus.fal_rsp_is_write_i;
          rsp_data_d     = bus.fal_rsp_data_i;
          state_d        = ST_RETURN;
        end
      end
      ST_RETURN: begin
        bus.rsp_valid_o[grant_q] = 1'b1;
        if (bus.rsp_ready_i[grant_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.fal_is_alloc_o = is_alloc_q;
  assign bus.fal_size_o     = size_q;
  assign bus.fal_addr_o     = addr_q;
  assign bus.rsp_is_write_o = rsp_is_write_q;
  assign bus.rsp_data_o     = rsp_data_q;
  assign busy_o             = (state_q != ST_IDLE);
  assign grant_idx_o        = grant_q;

  // A falafel result outside WAIT_RSP violates the one-result-per-request contract; it must never be accepted.
  a_no_spurious_accept: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.fal_rsp_valid_i && state_q != ST_WAIT_RSP) |-> !bus.fal_rsp_ready_o);

endmodule

// File: tb/tb_falafel_req_arbiter.sv
// Self-checking bench for falafel_req_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_falafel_req_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [1:0] grant_idx;

  always #5 clk = ~clk;

  falafel_req_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  falafel_req_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .busy_o      (busy),
    .grant_idx_o (grant_idx)
  );

  int n_checks = 0;
  int n_errors = 0;
  int rr = 0;

  bit          pend_v     [N];
  bit          pend_alloc [N];
  logic [63:0] pend_size  [N];
  logic [63:0] pend_addr  [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int r, input bit is_alloc, input logic [63:0] size, input logic [63:0] addr);
    pend_v[r]     = 1'b1;
    pend_alloc[r] = is_alloc;
    pend_size[r]  = size;
    pend_addr[r]  = addr;
  endtask

  task automatic new_req_rand(input int r);
    new_req(r, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      bus.req_valid_i[i]            = pend_v[i];
      bus.req_is_alloc_i[i]         = pend_alloc[i];
      bus.req_size_i[i*DW +: DW]    = pend_size[i];
      bus.req_addr_i[i*DW +: DW]    = pend_addr[i];
    end
  endtask

  // Round-robin rule: first pending requester at or after the pointer, wrapping.
  function automatic int pick();
    for (int i = 0; i < N; i++) begin
      int idx = (rr + i) % N;
      if (pend_v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"},     64'(bus.req_ready_o),     64'd0);
    check({tag, "_rsp_valid"},     64'(bus.rsp_valid_o),     64'd0);
    check({tag, "_rsp_is_write"},  64'(bus.rsp_is_write_o),  64'd0);
    check({tag, "_rsp_data"},      bus.rsp_data_o,           64'd0);
    check({tag, "_fal_req_valid"}, 64'(bus.fal_req_valid_o), 64'd0);
    check({tag, "_fal_is_alloc"},  64'(bus.fal_is_alloc_o),  64'd0);
    check({tag, "_fal_size"},      bus.fal_size_o,           64'd0);
    check({tag, "_fal_addr"},      bus.fal_addr_o,           64'd0);
    check({tag, "_fal_rsp_ready"}, 64'(bus.fal_rsp_ready_o), 64'd0);
    check({tag, "_busy"},          64'(busy),                64'd0);
    check({tag, "_grant_idx"},     64'(grant_idx),           64'd0);
  endtask

  // One arbitration starting in an idle cycle: n_stall cycles of falafel request
  // backpressure, n_wait cycles before the result, n_ret cycles of requester backpressure.
  task automatic run_txn(input int n_stall, input int n_wait, input int n_ret,
                         input logic [63:0] rdata, input bit rwr,
                         input bit rearm, input bit abort, input bit spur);
    int          exp;
    logic [N-1:0] oh;
    bus.fal_req_ready_i    = 1'b0;
    bus.fal_rsp_valid_i    = spur;
    bus.fal_rsp_is_write_i = 1'($urandom);
    bus.fal_rsp_data_i     = {$urandom, $urandom};
    bus.rsp_ready_i        = '0;
    drive_reqs();
    #1;
    exp = pick();
    check("idle_busy",          64'(busy),                64'd0);
    check("idle_fal_rsp_ready", 64'(bus.fal_rsp_ready_o), 64'd0);
    check("idle_rsp_valid",     64'(bus.rsp_valid_o),     64'd0);
    check("idle_fal_req_valid", 64'(bus.fal_req_valid_o), 64'd0);
    if (exp < 0) begin
      tick();
      bus.fal_rsp_valid_i = 1'b0;
      #1;
      check("stay_idle_busy",      64'(busy),            64'd0);
      check("stay_idle_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
      return;
    end
    oh      = '0;
    oh[exp] = 1'b1;
    tick();
    bus.fal_rsp_valid_i = 1'b0;
    rr = (exp + 1) % N;

    for (int k = 0; k <= n_stall; k++) begin
      bus.fal_req_ready_i = (k == n_stall);
      #1;
      check("issue_grant_idx",     64'(grant_idx),           64'(exp));
      check("issue_fal_req_valid", 64'(bus.fal_req_valid_o), 64'd1);
      check("issue_fal_is_alloc",  64'(bus.fal_is_alloc_o),  64'(pend_alloc[exp]));
      check("issue_fal_size",      bus.fal_size_o,           pend_size[exp]);
      check("issue_fal_addr",      bus.fal_addr_o,           pend_addr[exp]);
      check("issue_req_ready",     64'(bus.req_ready_o),     (k == n_stall) ? 64'(oh) : 64'd0);
      check("issue_busy",          64'(busy),                64'd1);
      tick();
    end
    bus.fal_req_ready_i = 1'b0;
    pend_v[exp] = 1'b0;
    if (rearm) new_req_rand(exp);
    drive_reqs();

    for (int k = 0; k <= n_wait; k++) begin
      if (abort && k == n_wait) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rr  = 0;
        #1;
        check_zero("after_rst");
        return;
      end
      bus.fal_rsp_valid_i    = (k == n_wait);
      bus.fal_rsp_data_i     = (k == n_wait) ? rdata : {$urandom, $urandom};
      bus.fal_rsp_is_write_i = (k == n_wait) ? rwr : ~rwr;
      #1;
      check("wait_fal_rsp_ready", 64'(bus.fal_rsp_ready_o), 64'd1);
      check("wait_fal_req_valid", 64'(bus.fal_req_valid_o), 64'd0);
      check("wait_req_ready",     64'(bus.req_ready_o),     64'd0);
      check("wait_rsp_valid",     64'(bus.rsp_valid_o),     64'd0);
      tick();
    end
    bus.fal_rsp_valid_i    = 1'b0;
    bus.fal_rsp_data_i     = ~rdata;
    bus.fal_rsp_is_write_i = ~rwr;

    for (int k = 0; k <= n_ret; k++) begin
      bus.rsp_ready_i      = N'($urandom);
      bus.rsp_ready_i[exp] = (k == n_ret);
      #1;
      check("ret_rsp_valid",     64'(bus.rsp_valid_o),     64'(oh));
      check("ret_rsp_data",      bus.rsp_data_o,           rdata);
      check("ret_rsp_is_write",  64'(bus.rsp_is_write_o),  64'(rwr));
      check("ret_fal_rsp_ready", 64'(bus.fal_rsp_ready_o), 64'd0);
      check("ret_busy",          64'(busy),                64'd1);
      check("ret_grant_idx",     64'(grant_idx),           64'(exp));
      tick();
    end
    bus.rsp_ready_i = '0;
  endtask

  initial begin
    rst                    = 1'b1;
    bus.req_valid_i        = '0;
    bus.req_is_alloc_i     = '0;
    bus.req_size_i         = '0;
    bus.req_addr_i         = '0;
    bus.rsp_ready_i        = '0;
    bus.fal_req_ready_i    = 1'b0;
    bus.fal_rsp_valid_i    = 1'b0;
    bus.fal_rsp_is_write_i = 1'b0;
    bus.fal_rsp_data_i     = '0;
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0; pend_alloc[i] = 1'b0; pend_size[i] = '0; pend_addr[i] = '0;
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_zero("reset");

    // All four valid from reset: grants 0,1,2,3,0 then drain 1,2,3,0.
    for (int i = 0; i < N; i++) new_req_rand(i);
    for (int t = 0; t < 9; t++)
      run_txn(0, 0, 0, {$urandom, $urandom}, 1'($urandom), (t < 5), 1'b0, 1'b0);

    // Single alloc from requester 1.
    new_req(1, 1'b1, 64'h40, {$urandom, $urandom});
    run_txn(0, 2, 2, 64'h1000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Free from requester 2.
    new_req(2, 1'b0, {$urandom, $urandom}, 64'h2000);
    run_txn(0, 1, 1, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 1'b0);

    // Backpressure on requester 3 with requester 0 waiting.
    new_req_rand(0);
    new_req_rand(3);
    run_txn(5, 1, 4, {$urandom, $urandom}, 1'($urandom), 1'b0, 1'b0, 1'b0);
    run_txn(1, 0, 1, {$urandom, $urandom}, 1'($urandom), 1'b0, 1'b0, 1'b0);

    // Reset in WAIT_RSP while requester 1 is granted; pointer must restart at 0.
    new_req_rand(0);
    new_req_rand(1);
    new_req_rand(2);
    run_txn(0, 2, 0, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1, 1'b0);
    run_txn(0, 0, 0, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 1'b0);
    run_txn(0, 0, 0, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 1'b0);

    // Spurious falafel results while idle with nothing pending.
    run_txn(0, 0, 0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_txn(0, 0, 0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++)
        if (!pend_v[i] && $urandom_range(2) == 0) new_req_rand(i);
      run_txn($urandom_range(3), $urandom_range(3), $urandom_range(3),
              {$urandom, $urandom}, 1'($urandom),
              ($urandom_range(3) == 0), ($urandom_range(15) == 0), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
